// File: rtl/mul_accumulator.sv
// Purpose : sums fixed-size groups of COUNT unsigned products into an ACC_W accumulator.
// Latency : sum follows each accept by one cycle; out_valid rises the cycle after the COUNT-th accept.
// Backpr. : DONE holds sum/overflow and deasserts in_ready until out_ready.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   clear                synchronous abort of the group in progress
//   in_valid/in_ready    product handshake; product is IN_W bits, unsigned
//   out_valid/out_ready  group result handshake; sum is ACC_W bits
//   overflow             sticky carry-out of the accumulator within the current group
//   busy                 a group is partially accumulated or a result is pending
module mul_accumulator #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    // One extra bit on top of the accumulator captures the carry-out.
    logic [ACC_W:0]    add_ext;

    assign add_ext = {1'b0, acc_q} + (ACC_W + 1)'(product);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            // Abort wins over both accept and handoff; a product offered now is dropped.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = add_ext[ACC_W-1:0];
                        ovf_d = ovf_q | add_ext[ACC_W];
                        if (cnt_q == CNT_W'(COUNT - 1)) begin
                            // Final product of the group: park cnt at COUNT while the result waits.
                            cnt_d   = CNT_W'(COUNT);
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // All outputs are decoded from registers only.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign sum       = acc_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == DONE) || (cnt_q != '0);

endmodule

// File: tb/tb_mul_accumulator.sv
module tb_mul_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: default parameters
    logic       reset_a, clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, overflow_a, busy_a;
    logic [3:0] product_a;
    logic [7:0] sum_a;

    // Instance B: ACC_W=5 for wrap-around
    logic       reset_bc, clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, overflow_b, busy_b;
    logic [3:0] product_b;
    logic [4:0] sum_b;

    // Instance C: COUNT=1
    logic       clear_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c, overflow_c, busy_c;
    logic [3:0] product_c;
    logic [7:0] sum_c;

    mul_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(4)) dut_a (
        .clk(clk), .reset(reset_a), .clear(clear_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .product(product_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .sum(sum_a),
        .overflow(overflow_a), .busy(busy_a)
    );

    mul_accumulator #(.IN_W(4), .ACC_W(5), .COUNT(4)) dut_b (
        .clk(clk), .reset(reset_bc), .clear(clear_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .product(product_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .sum(sum_b),
        .overflow(overflow_b), .busy(busy_b)
    );

    mul_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(1)) dut_c (
        .clk(clk), .reset(reset_bc), .clear(clear_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .product(product_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .sum(sum_c),
        .overflow(overflow_c), .busy(busy_c)
    );

    // Expected group results, encoded as overflow*1024 + sum.
    int q_a[$];
    int q_b[$];
    int q_c[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a result is consumed when valid and ready meet with no reset/clear overriding.
    always @(negedge clk) begin
        if (!reset_a && !clear_a && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) chk("mon_a_unexpected", 1, 0);
            else chk("mon_a_result", int'(overflow_a) * 1024 + int'(sum_a), q_a.pop_front());
        end
        if (!reset_bc && !clear_b && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) chk("mon_b_unexpected", 1, 0);
            else chk("mon_b_result", int'(overflow_b) * 1024 + int'(sum_b), q_b.pop_front());
        end
        if (!reset_bc && !clear_c && out_valid_c && out_ready_c) begin
            if (q_c.size() == 0) chk("mon_c_unexpected", 1, 0);
            else chk("mon_c_result", int'(overflow_c) * 1024 + int'(sum_c), q_c.pop_front());
        end
    end

    // Offer one product to A and return just after the edge that accepts it.
    task automatic feed_a(input logic [3:0] p);
        int t;
        t = 0;
        in_valid_a = 1'b1;
        product_a  = p;
        while (!in_ready_a && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("feed_a_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        reset_a = 1'b1; reset_bc = 1'b1;
        clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        product_a = '0; product_b = '0; product_c = '0;
        out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
        repeat (2) step();
        reset_a = 1'b0; reset_bc = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready_a), 1);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_sum", int'(sum_a), 0);
        chk("rst_overflow", int'(overflow_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        step();

        // Basic group: 3+5+15+15 = 38
        q_a.push_back(38);
        feed_a(4'd3); feed_a(4'd5); feed_a(4'd15); feed_a(4'd15);
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("basic_out_valid", int'(out_valid_a), 1);
        step();
        chk("basic_after_valid", int'(out_valid_a), 0);
        chk("basic_after_sum", int'(sum_a), 0);
        chk("basic_after_busy", int'(busy_a), 0);

        // Back-pressure: 1+1+1+1 = 4 held for 6 cycles while 9 waits at the input
        out_ready_a = 1'b0;
        q_a.push_back(4);
        feed_a(4'd1); feed_a(4'd1); feed_a(4'd1); feed_a(4'd1);
        in_valid_a = 1'b1;
        product_a  = 4'd9;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready_a), 0);
            chk("bp_sum", int'(sum_a), 4);
            chk("bp_out_valid", int'(out_valid_a), 1);
            step();
        end
        out_ready_a = 1'b1;
        step();
        chk("bp_handoff_in_ready", int'(in_ready_a), 1);
        chk("bp_handoff_sum", int'(sum_a), 0);
        step();
        chk("bp_next_sum", int'(sum_a), 9);
        chk("bp_next_busy", int'(busy_a), 1);
        in_valid_a = 1'b0;

        // Clear mid-group: partial group (9,7,7) abandoned, product offered with clear dropped
        feed_a(4'd7); feed_a(4'd7);
        chk("clr_pre_sum", int'(sum_a), 23);
        clear_a = 1'b1; in_valid_a = 1'b1; product_a = 4'd7;
        step();
        clear_a = 1'b0; in_valid_a = 1'b0;
        chk("clr_sum", int'(sum_a), 0);
        chk("clr_busy", int'(busy_a), 0);
        q_a.push_back(10);
        feed_a(4'd1); feed_a(4'd2); feed_a(4'd3); feed_a(4'd4);
        in_valid_a = 1'b0;
        step(); step();
        chk("clr_group_done", int'(out_valid_a), 0);

        // Gaps keep busy high; reset in DONE with out_ready high discards the result
        feed_a(4'd2);
        in_valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gap_busy", int'(busy_a), 1);
            step();
        end
        feed_a(4'd2);
        chk("gap_sum", int'(sum_a), 4);
        chk("gap_busy2", int'(busy_a), 1);
        out_ready_a = 1'b0;
        feed_a(4'd0); feed_a(4'd0);
        in_valid_a = 1'b0;
        chk("gap_done_valid", int'(out_valid_a), 1);
        out_ready_a = 1'b1;
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        chk("rst_done_valid", int'(out_valid_a), 0);
        chk("rst_done_sum", int'(sum_a), 0);
        chk("rst_done_busy", int'(busy_a), 0);
        chk("rst_done_in_ready", int'(in_ready_a), 1);

        // Wrap and sticky overflow: 15+15+15+0 = 45 -> 13 mod 32
        q_b.push_back(1024 + 13);
        in_valid_b = 1'b1;
        product_b = 4'd15; step();
        chk("wrap_ovf_early", int'(overflow_b), 0);
        step(); step();
        chk("wrap_ovf_set", int'(overflow_b), 1);
        chk("wrap_sum3", int'(sum_b), 13);
        product_b = 4'd0; step();
        in_valid_b = 1'b0;
        chk("wrap_done_valid", int'(out_valid_b), 1);
        step();
        chk("wrap_ovf_cleared", int'(overflow_b), 0);
        chk("wrap_valid_cleared", int'(out_valid_b), 0);

        // COUNT=1: 6 then 9, result pulses two cycles apart
        q_c.push_back(6);
        q_c.push_back(9);
        in_valid_c = 1'b1; product_c = 4'd6;
        step();
        product_c = 4'd9;
        @(negedge clk);
        chk("c1_valid1", int'(out_valid_c), 1);
        chk("c1_sum1", int'(sum_c), 6);
        step();
        @(negedge clk);
        chk("c1_gap", int'(out_valid_c), 0);
        step();
        in_valid_c = 1'b0;
        @(negedge clk);
        chk("c1_valid2", int'(out_valid_c), 1);
        chk("c1_sum2", int'(sum_c), 9);
        step();
        @(negedge clk);
        chk("c1_idle", int'(out_valid_c), 0);
        step();

        // Every expected result must have been observed
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        chk("q_c_drained", q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
